// File: rtl/mdu_pkg.sv
// Shared encodings for the HI/LO multiply/divide controller: request opcodes,
// shared-ALU operation codes and the controller state enum.
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_NONE = 3'b000,
        OP_MULT = 3'b001,
        OP_DIV  = 3'b010,
        OP_MTHI = 3'b011,
        OP_MTLO = 3'b100,
        OP_MFHI = 3'b101,
        OP_MFLO = 3'b110,
        OP_RSVD = 3'b111
    } mdu_op_e;

    localparam logic [3:0] ALUOP_MUL  = 4'b0011;
    localparam logic [3:0] ALUOP_DIV  = 4'b0100;
    localparam logic [3:0] ALUOP_IDLE = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } mdu_state_e;

    localparam int CNT_W = 5;

    // The reserved opcode behaves exactly like "none".
    function automatic logic op_is_real(input mdu_op_e op);
        return (op != OP_NONE) && (op != OP_RSVD);
    endfunction

endpackage

// File: rtl/hilo_mdu_ctrl.sv
// HI/LO multiply/divide sequencer: drives an external shared ALU for a fixed
// latency, then commits the 64-bit result into the architectural HI/LO pair.
module hilo_mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        flush,
    output logic        req_ready,
    output logic        stall,
    output logic [31:0] alu_x,
    output logic [31:0] alu_y,
    output logic [3:0]  aluop,
    input  logic [31:0] alu_re1,
    input  logic [31:0] alu_re2,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        busy,
    output logic        done,
    output logic        dz
);

    localparam logic [CNT_W-1:0] MUL_CNT_INIT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT_INIT = CNT_W'(DIV_LAT - 1);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      x_q, x_d;
    logic [31:0]      y_q, y_d;
    logic [31:0]      rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;

    mdu_op_e          op;
    logic             accept;

    assign op        = mdu_op_e'(req_op);
    assign req_ready = (state_q == ST_IDLE) && !flush;
    assign stall     = req_valid && !req_ready;
    assign accept    = req_valid && req_ready && op_is_real(op);

    assign busy      = (state_q != ST_IDLE);
    assign alu_x     = x_q;
    assign alu_y     = y_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign done      = done_q;
    assign dz        = dz_q;

    always_comb begin
        aluop = ALUOP_IDLE;
        case (state_q)
            ST_MUL:  aluop = ALUOP_MUL;
            ST_DIV:  aluop = ALUOP_DIV;
            default: aluop = ALUOP_IDLE;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        x_d        = x_q;
        y_d        = y_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        done_d     = 1'b0;
        dz_d       = 1'b0;

        if (flush) begin
            // Kill wins over everything, including a terminal count this cycle.
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        case (op)
                            OP_MULT: begin
                                x_d     = rs_val;
                                y_d     = rt_val;
                                cnt_d   = MUL_CNT_INIT;
                                state_d = ST_MUL;
                            end
                            OP_DIV: begin
                                if (rt_val == 32'd0) begin
                                    dz_d = 1'b1;
                                end else begin
                                    x_d     = rs_val;
                                    y_d     = rt_val;
                                    cnt_d   = DIV_CNT_INIT;
                                    state_d = ST_DIV;
                                end
                            end
                            OP_MTHI: hi_d = rs_val;
                            OP_MTLO: lo_d = rs_val;
                            OP_MFHI: begin
                                rd_data_d  = hi_q;
                                rd_valid_d = 1'b1;
                            end
                            OP_MFLO: begin
                                rd_data_d  = lo_q;
                                rd_valid_d = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_MUL: begin
                    if (cnt_q == '0) begin
                        hi_d    = alu_re1;
                        lo_d    = alu_re2;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_DIV: begin
                    // ALU returns quotient on re1 and remainder on re2.
                    if (cnt_q == '0) begin
                        lo_d    = alu_re1;
                        hi_d    = alu_re2;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            x_q        <= '0;
            y_q        <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            dz_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            x_q        <= x_d;
            y_q        <= y_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
            dz_q       <= dz_d;
        end
    end

endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// Directed bench for hilo_mdu_ctrl with a behavioural shared ALU and
// scoreboard queues for completions, register reads and divide-by-zero pulses.
module tb_hilo_mdu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] rs_val, rt_val;
    logic        flush;
    logic        req_ready, stall;
    logic [31:0] alu_x, alu_y;
    logic [3:0]  aluop;
    logic [31:0] alu_re1, alu_re2;
    logic [31:0] hi, lo, rd_data;
    logic        rd_valid, busy, done, dz;

    int vectors = 0;
    int miscompares = 0;

    logic [63:0] done_q[$];
    logic [31:0] rd_q[$];
    int          dz_pend = 0;
    logic [31:0] m_hi = 0, m_lo = 0;

    always #5 clk = ~clk;

    hilo_mdu_ctrl #(.MUL_LAT(4), .DIV_LAT(16)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
        .rs_val(rs_val), .rt_val(rt_val), .flush(flush),
        .req_ready(req_ready), .stall(stall),
        .alu_x(alu_x), .alu_y(alu_y), .aluop(aluop),
        .alu_re1(alu_re1), .alu_re2(alu_re2),
        .hi(hi), .lo(lo), .rd_data(rd_data), .rd_valid(rd_valid),
        .busy(busy), .done(done), .dz(dz)
    );

    // External shared ALU
    logic signed [63:0] alu_prod;
    always_comb begin
        alu_re1  = 32'd0;
        alu_re2  = 32'd0;
        alu_prod = 64'sd0;
        if (aluop == 4'b0011) begin
            alu_prod = $signed(alu_x) * $signed(alu_y);
            alu_re1  = alu_prod[63:32];
            alu_re2  = alu_prod[31:0];
        end else if (aluop == 4'b0100 && alu_y != 32'd0) begin
            alu_re1 = $signed(alu_x) / $signed(alu_y);
            alu_re2 = $signed(alu_x) % $signed(alu_y);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Holds the request until accepted; returns one cycle after acceptance.
    task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
        bit acc = 0;
        req_valid = 1'b1; req_op = op; rs_val = rs; rt_val = rt;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0; req_op = 3'b000;
        if (!acc) chk("issue_timeout", {31'd0, acc}, 32'd1);
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] p;
        p = $signed(a) * $signed(b);
        return p;
    endfunction

    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] q, r;
        q = $signed(a) / $signed(b);
        r = $signed(a) - q * $signed(b);
        return {r, q};
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (done) begin
                if (done_q.size() == 0) chk("done_unexpected", {31'd0, done}, 32'd0);
                else begin
                    logic [63:0] e;
                    e = done_q.pop_front();
                    chk("done_hi", hi, e[63:32]);
                    chk("done_lo", lo, e[31:0]);
                end
            end
            if (rd_valid) begin
                if (rd_q.size() == 0) chk("rd_unexpected", {31'd0, rd_valid}, 32'd0);
                else chk("rd_data", rd_data, rd_q.pop_front());
            end
            if (dz) begin
                if (dz_pend == 0) chk("dz_unexpected", {31'd0, dz}, 32'd0);
                else dz_pend--;
            end
        end
    end

    initial begin
        logic [63:0] r;
        logic [31:0] a, b;
        rst_n = 1'b0; req_valid = 1'b0; req_op = 3'b000;
        rs_val = 0; rt_val = 0; flush = 1'b0;
        step(3);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_alu_x", alu_x, 0);
        chk("rst_alu_y", alu_y, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_flags", {28'd0, rd_valid, done, dz, busy}, 0);
        chk("rst_aluop", {28'd0, aluop}, 32'hF);
        rst_n = 1'b1;
        step(1);
        chk("idle_ready", {31'd0, req_ready}, 1);

        // Moves to/from HI/LO
        issue(3'b011, 32'hAAAA5555, 0); m_hi = 32'hAAAA5555;
        chk("mthi_hi", hi, m_hi);
        chk("mthi_busy", {31'd0, busy}, 0);
        issue(3'b100, 32'h00001234, 0); m_lo = 32'h00001234;
        chk("mtlo_lo", lo, m_lo);
        rd_q.push_back(m_hi); issue(3'b101, 0, 0);
        rd_q.push_back(m_lo); issue(3'b110, 0, 0);

        // MULT 0x10000 * 0x10000: busy 4 cycles, done at T+5
        done_q.push_back({32'h1, 32'h0}); m_hi = 32'h1; m_lo = 32'h0;
        issue(3'b001, 32'h00010000, 32'h00010000);
        chk("mul_aluop", {28'd0, aluop}, 32'h3);
        chk("mul_alu_x", alu_x, 32'h00010000);
        for (int k = 0; k < 4; k++) begin
            chk("mul_busy", {31'd0, busy}, 1);
            step(1);
        end
        chk("mul_done", {31'd0, done}, 1);
        chk("mul_busy_end", {31'd0, busy}, 0);
        chk("mul_ready_end", {31'd0, req_ready}, 1);
        chk("mul_hi", hi, 32'h1);
        chk("mul_lo", lo, 32'h0);
        chk("idle_aluop", {28'd0, aluop}, 32'hF);

        // DIV -7 / 2
        done_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFD}); m_hi = 32'hFFFFFFFF; m_lo = 32'hFFFFFFFD;
        issue(3'b010, 32'hFFFFFFF9, 32'd2);
        chk("div_aluop", {28'd0, aluop}, 32'h4);
        step(15);
        chk("div_done_early", {31'd0, done}, 0);
        step(1);
        chk("div_done", {31'd0, done}, 1);
        chk("div_lo", lo, 32'hFFFFFFFD);
        chk("div_hi", hi, 32'hFFFFFFFF);

        // DIV 5 / 0
        dz_pend++;
        issue(3'b010, 32'd5, 32'd0);
        chk("dz_pulse", {31'd0, dz}, 1);
        chk("dz_busy", {31'd0, busy}, 0);
        chk("dz_hi", hi, m_hi);
        chk("dz_lo", lo, m_lo);
        step(1);
        chk("dz_clear", {31'd0, dz}, 0);
        chk("dz_busy2", {31'd0, busy}, 0);

        // MULT then MFLO next cycle: 4 stall cycles
        r = ref_mul(32'hFFFFFFFE, 32'd3);
        done_q.push_back(r); m_hi = r[63:32]; m_lo = r[31:0];
        issue(3'b001, 32'hFFFFFFFE, 32'd3);
        rd_q.push_back(m_lo);
        req_valid = 1'b1; req_op = 3'b110;
        for (int k = 0; k < 4; k++) begin
            chk("mflo_stall", {31'd0, stall}, 1);
            step(1);
        end
        chk("mflo_stall_end", {31'd0, stall}, 0);
        step(1);
        req_valid = 1'b0; req_op = 3'b000;
        chk("mflo_rd_valid", {31'd0, rd_valid}, 1);
        chk("mflo_rd_data", rd_data, 32'hFFFFFFFA);

        // Flush in third cycle of DIV, with a competing MTHI
        issue(3'b010, 32'd100, 32'd7);
        step(2);
        flush = 1'b1; req_valid = 1'b1; req_op = 3'b011; rs_val = 32'hDEADBEEF;
        chk("flush_ready", {31'd0, req_ready}, 0);
        step(1);
        flush = 1'b0; req_valid = 1'b0; req_op = 3'b000;
        chk("flush_busy", {31'd0, busy}, 0);
        chk("flush_hi", hi, m_hi);
        chk("flush_lo", lo, m_lo);
        chk("flush_done", {31'd0, done}, 0);
        step(20);

        // Flush coinciding with terminal count of MULT
        issue(3'b001, 32'd9, 32'd9);
        step(3);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        chk("flushtc_done", {31'd0, done}, 0);
        chk("flushtc_hi", hi, m_hi);
        chk("flushtc_lo", lo, m_lo);
        step(3);

        // Reserved and none opcodes do nothing
        req_valid = 1'b1; req_op = 3'b111; rs_val = 32'h55555555; rt_val = 32'd0;
        step(1);
        req_op = 3'b000;
        step(1);
        req_valid = 1'b0;
        chk("rsvd_busy", {31'd0, busy}, 0);
        chk("rsvd_hi", hi, m_hi);
        chk("rsvd_lo", lo, m_lo);

        // Randomised MULT/DIV with readback
        for (int n = 0; n < 6; n++) begin
            a = $urandom;
            b = $urandom | 32'd1;
            if (a == 32'h80000000) a = 32'd1;
            r = (n % 2 == 0) ? ref_mul(a, b) : ref_div(a, b);
            done_q.push_back(r); m_hi = r[63:32]; m_lo = r[31:0];
            issue((n % 2 == 0) ? 3'b001 : 3'b010, a, b);
            rd_q.push_back(m_hi); issue(3'b101, 0, 0);
            rd_q.push_back(m_lo); issue(3'b110, 0, 0);
        end

        // Reset during MUL
        issue(3'b001, 32'h00000123, 32'h00000456);
        step(1);
        rst_n = 1'b0;
        step(1);
        chk("midrst_hi", hi, 0);
        chk("midrst_lo", lo, 0);
        chk("midrst_alu_x", alu_x, 0);
        chk("midrst_alu_y", alu_y, 0);
        chk("midrst_rd_data", rd_data, 0);
        chk("midrst_flags", {28'd0, rd_valid, done, dz, busy}, 0);
        rst_n = 1'b1; m_hi = 0; m_lo = 0;
        step(1);
        issue(3'b011, 32'h12345678, 0);
        chk("postrst_hi", hi, 32'h12345678);
        chk("postrst_lo", lo, 32'h0);
        step(8);

        chk("done_q_empty", done_q.size(), 0);
        chk("rd_q_empty", rd_q.size(), 0);
        chk("dz_pend_zero", dz_pend, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hilo_mdu_ctrl.md
HILO_MDU_CTRL -- requirements
Module: hilo_mdu_ctrl

Interface
REQ-001 Parameter MUL_LAT, default 4, SHALL set the multiply latency in cycles; legal range is 1..31.
REQ-002 Parameter DIV_LAT, default 16, SHALL set the divide latency in cycles; legal range is 1..31.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  SHALL be the reset: synchronous, active-low.
REQ-005 req_valid  in  1  SHALL indicate that a HI/LO operation is requested.
REQ-006 req_op  in  3  SHALL select the operation: 000 none, 001 MULT, 010 DIV, 011 MTHI, 100 MTLO, 101 MFHI, 110 MFLO; 111 is reserved.
REQ-007 rs_val, rt_val  in  32 each  SHALL carry the source operands.
REQ-008 flush  in  1  SHALL abort any in-flight operation (exception/branch kill).
REQ-009 req_ready  out  1  SHALL indicate that the request is accepted this cycle.
REQ-010 stall  out  1  SHALL equal req_valid & ~req_ready.
REQ-011 alu_x, alu_y  out  32 each; aluop  out  4  SHALL drive the shared ALU.
REQ-012 alu_re1, alu_re2  in  32 each  SHALL be the ALU results.
REQ-013 hi, lo  out  32 each  SHALL present the architectural HI/LO registers.
REQ-014 rd_data  out  32; rd_valid  out  1  SHALL return MFHI/MFLO data.
REQ-015 busy  out  1; done  out  1; dz  out  1  SHALL give status, a completion pulse and a divide-by-zero pulse respectively.

Function
REQ-016 States SHALL be IDLE, MUL, DIV; req_ready = (state==IDLE) & ~flush.
REQ-017 Acceptance SHALL occur at cycle T when req_valid & req_ready & req_op!=000.
REQ-018 MULT accepted at T SHALL latch rs_val/rt_val into alu_x/alu_y, enter MUL and load cnt=MUL_LAT-1.
REQ-019 DIV accepted at T SHALL do the same as MULT, but enter DIV and load cnt=DIV_LAT-1.
REQ-020 In MUL/DIV, cnt SHALL decrement each cycle; busy=1.
REQ-021 At cnt==0, the block SHALL write HI/LO and return to IDLE; new HI/LO, done=1 and req_ready are all visible in cycle T+LAT+1.
REQ-022 MUL SHALL drive aluop=0011 and write HI=alu_re1, LO=alu_re2 (signed 64-bit product).
REQ-023 DIV SHALL drive aluop=0100 and write LO=alu_re1 (quotient), HI=alu_re2 (remainder, sign of dividend).
REQ-024 In IDLE, aluop SHALL be 1111; alu_x and alu_y hold their last values.
REQ-025 DIV with rt_val==0 SHALL NOT enter DIV, SHALL leave HI/LO unchanged, and SHALL pulse dz in T+1.
REQ-026 MTHI/MTLO SHALL write rs_val to HI/LO, visible at T+1, with no busy period.
REQ-027 MFHI/MFLO SHALL set rd_data=hi/lo and rd_valid=1 in T+1; rd_valid is 0 otherwise.
REQ-028 MFHI/MFLO/MT*/MULT/DIV issued while busy SHALL stall (req_ready=0) until IDLE; no request SHALL be dropped or duplicated.
REQ-029 flush in any state SHALL force IDLE next cycle, leave HI/LO unchanged, suppress done, and accept no request that cycle.
REQ-030 If flush and cnt==0 occur in the same cycle, flush SHALL win and no write occurs.
REQ-031 req_op 111 SHALL be treated as none.

Reset
REQ-032 When rst_n==0 at an edge: state=IDLE, cnt=0, hi=lo=0, alu_x=alu_y=0, rd_data=0; rd_valid, done, dz, busy = 0.
REQ-033 Reset mid-operation SHALL discard the operation, with no HI/LO write.

Structure
REQ-034 Package mdu_pkg SHALL hold the req_op encodings, the aluop constants (0011, 0100, 1111) and the state enum.
REQ-035 The block SHALL have no sub-module; the ALU is instantiated externally and shared through alu_x/alu_y/aluop.

Verification
REQ-036 MULT 0x00010000 × 0x00010000 -> busy for 4 cycles; HI=0x00000001, LO=0x00000000, done at T+5.
REQ-037 DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF at T+17.
REQ-038 DIV 5 / 0 -> dz pulse at T+1; HI/LO unchanged; busy never set.
REQ-039 MULT, then MFLO the next cycle -> stall=1 for 4 cycles, then rd_data=new LO.
REQ-040 flush at cycle 3 of a DIV -> IDLE, HI/LO unchanged, no done.
REQ-041 rst_n low during MUL -> all outputs at reset values; following MTHI 0x12345678 -> hi=0x12345678.
